// File: rtl/game_pkg.sv
// Shared game constants: FSM encoding, screen geometry and the goal rectangle
// that both the maze renderer and the win controller must agree on.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // First blanking line doubles as the frame boundary.
  localparam int FRAME_LINE_DEF = SCREEN_H;

  localparam int GOAL_W_DEF = 40;
  localparam int GOAL_H_DEF = 40;
  localparam int GOAL_X_DEF = SCREEN_W - 2 * GOAL_W_DEF;
  localparam int GOAL_Y_DEF = SCREEN_H - 2 * GOAL_H_DEF;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_OVER    = 2'd2,
    ST_RESTART = 2'd3
  } win_state_e;

endpackage

// File: rtl/frame_pulse.sv
// One-cycle registered pulse marking the start of vertical blanking.
module frame_pulse #(
  parameter int FRAME_LINE = game_pkg::FRAME_LINE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vert,
  input  logic [9:0] horz,
  output logic       frame_tick
);

  always_ff @(posedge clk) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= (vert == 10'(FRAME_LINE)) && (horz == 10'd0);
  end

endmodule

// File: rtl/win_state_ctrl.sv
// Game-state controller: confirms the icon is in the goal over several frames,
// shows the splash for a minimum time, then restarts on a button press.
module win_state_ctrl
  import game_pkg::*;
#(
  parameter int GOAL_X          = GOAL_X_DEF,
  parameter int GOAL_Y          = GOAL_Y_DEF,
  parameter int GOAL_W          = GOAL_W_DEF,
  parameter int GOAL_H          = GOAL_H_DEF,
  parameter int FRAME_LINE      = FRAME_LINE_DEF,
  parameter int CONFIRM_FRAMES  = 3,
  parameter int MIN_HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vert,
  input  logic [9:0] horz,
  input  logic [9:0] icon_x,
  input  logic [9:0] icon_y,
  input  logic       btn_restart,
  output logic       gameover,
  output logic       restart,
  output logic       frame_tick,
  output logic [7:0] win_count
);

  // 11-bit bounds so GOAL+W cannot wrap against a 10-bit position.
  localparam logic [10:0] X_LO = 11'(GOAL_X);
  localparam logic [10:0] X_HI = 11'(GOAL_X + GOAL_W);
  localparam logic [10:0] Y_LO = 11'(GOAL_Y);
  localparam logic [10:0] Y_HI = 11'(GOAL_Y + GOAL_H);

  win_state_e state, state_d;
  logic [3:0] confirm_cnt, confirm_d;
  logic [7:0] hold_cnt, hold_d;
  logic [7:0] win_d;
  logic       restart_d;
  logic       btn_prev;
  logic       btn_rise;
  logic       in_goal;
  logic       hold_met;
  logic       enter_over;

  frame_pulse #(.FRAME_LINE(FRAME_LINE)) u_frame_pulse (
    .clk        (clk),
    .reset      (reset),
    .vert       (vert),
    .horz       (horz),
    .frame_tick (frame_tick)
  );

  assign in_goal  = ({1'b0, icon_x} >= X_LO) && ({1'b0, icon_x} < X_HI) &&
                    ({1'b0, icon_y} >= Y_LO) && ({1'b0, icon_y} < Y_HI);
  assign btn_rise = btn_restart && !btn_prev;
  // hold_cnt >= MIN, phrased so a zero minimum does not fold to a constant compare.
  assign hold_met = ({1'b0, hold_cnt} + 9'd1) > 9'(MIN_HOLD_FRAMES);
  // Splash spans OVER and RESTART; both transitions happen only on frame ticks.
  assign gameover = (state == ST_OVER) || (state == ST_RESTART);

  always_comb begin
    state_d    = state;
    confirm_d  = confirm_cnt;
    hold_d     = hold_cnt;
    win_d      = win_count;
    restart_d  = 1'b0;
    enter_over = 1'b0;
    case (state)
      ST_PLAY: begin
        if (frame_tick && in_goal) begin
          if (CONFIRM_FRAMES == 1) enter_over = 1'b1;
          else begin
            confirm_d = 4'd1;
            state_d   = ST_CONFIRM;
          end
        end
      end
      ST_CONFIRM: begin
        if (frame_tick) begin
          if (!in_goal) begin
            confirm_d = 4'd0;
            state_d   = ST_PLAY;
          end else begin
            confirm_d = confirm_cnt + 4'd1;
            if (confirm_d == 4'(CONFIRM_FRAMES)) enter_over = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (frame_tick && hold_cnt != 8'hff) hold_d = hold_cnt + 8'd1;
        // Compare uses the pre-increment hold count.
        if (btn_rise && hold_met) state_d = ST_RESTART;
      end
      ST_RESTART: begin
        if (frame_tick) begin
          restart_d = 1'b1;
          confirm_d = 4'd0;
          state_d   = ST_PLAY;
        end
      end
      default: state_d = ST_PLAY;
    endcase
    if (enter_over) begin
      state_d   = ST_OVER;
      confirm_d = 4'd0;
      hold_d    = 8'd0;
      if (win_count != 8'hff) win_d = win_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_PLAY;
      confirm_cnt <= 4'd0;
      hold_cnt    <= 8'd0;
      win_count   <= 8'd0;
      restart     <= 1'b0;
      btn_prev    <= 1'b0;
    end else begin
      state       <= state_d;
      confirm_cnt <= confirm_d;
      hold_cnt    <= hold_d;
      win_count   <= win_d;
      restart     <= restart_d;
      btn_prev    <= btn_restart;
    end
  end

endmodule

// File: tb/tb_win_state_ctrl.sv
// Directed bench for win_state_ctrl: default-parameter instance plus a
// CONFIRM=1 / HOLD=0 instance for win_count saturation.
module tb_win_state_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] vert, horz, icon_x, icon_y;
  logic       btn_restart;
  logic       gameover, restart, frame_tick;
  logic [7:0] win_count;
  logic       gameover2, restart2, frame_tick2;
  logic [7:0] win_count2;

  int total = 0;
  int bad   = 0;
  int tick_seen = 0;
  int restart_seen = 0;

  always #5 clk = ~clk;

  win_state_ctrl dut (
    .clk(clk), .reset(reset), .vert(vert), .horz(horz),
    .icon_x(icon_x), .icon_y(icon_y), .btn_restart(btn_restart),
    .gameover(gameover), .restart(restart), .frame_tick(frame_tick),
    .win_count(win_count)
  );

  win_state_ctrl #(.CONFIRM_FRAMES(1), .MIN_HOLD_FRAMES(0)) dut2 (
    .clk(clk), .reset(reset), .vert(vert), .horz(horz),
    .icon_x(icon_x), .icon_y(icon_y), .btn_restart(btn_restart),
    .gameover(gameover2), .restart(restart2), .frame_tick(frame_tick2),
    .win_count(win_count2)
  );

  always @(posedge clk) begin
    if (frame_tick) tick_seen++;
    if (restart)    restart_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the boundary line for one cycle; returns with frame_tick high.
  task automatic tick_hi();
    vert = 10'd480; horz = 10'd0;
    cyc(1);
    vert = 10'd0; horz = 10'd1;
    chk("tick_hi", frame_tick, 1);
  endtask

  // Full frame: tick, FSM edge, then idle padding.
  task automatic frame();
    tick_hi();
    cyc(1);
    chk("tick_lo", frame_tick, 0);
    cyc(2);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic set_icon(input int x, input int y);
    icon_x = 10'(x); icon_y = 10'(y);
  endtask

  initial begin
    reset = 1'b1; vert = 10'd0; horz = 10'd1; btn_restart = 1'b0;
    set_icon(0, 0);
    cyc(3);
    chk("rst_gameover", gameover, 0);
    chk("rst_restart", restart, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_win", win_count, 0);
    reset = 1'b0;
    cyc(2);

    // Icon far from goal for 10 frames.
    tick_seen = 0;
    frames(10);
    chk("idle_ticks", tick_seen, 10);
    chk("idle_gameover", gameover, 0);
    chk("idle_restart_cnt", restart_seen, 0);
    chk("idle_win", win_count, 0);

    // Two in-goal frames, one out, then three consecutive in.
    set_icon(560, 400); frames(2);
    chk("confirm2_go", gameover, 0);
    set_icon(100, 100); frame();
    chk("break_go", gameover, 0);
    set_icon(560, 400); frames(2);
    chk("reconfirm2_go", gameover, 0);
    tick_hi();
    chk("win_pre_edge", gameover, 0);
    cyc(1);
    chk("win_post_edge", gameover, 1);
    chk("win_count1", win_count, 1);
    cyc(2);

    // Early press at hold=30 is discarded; held button must not retrigger.
    set_icon(0, 0);
    frames(30);
    btn_restart = 1'b1; cyc(1);
    frames(32);
    chk("held_go", gameover, 1);
    chk("held_restart_cnt", restart_seen, 0);
    btn_restart = 1'b0; cyc(1);
    btn_restart = 1'b1; cyc(1);
    btn_restart = 1'b0; cyc(3);
    chk("rst_wait_go", gameover, 1);
    chk("rst_wait_pulse", restart, 0);
    tick_hi();
    chk("rst_tick_go", gameover, 1);
    chk("rst_tick_pulse", restart, 0);
    cyc(1);
    chk("rst_exit_go", gameover, 0);
    chk("rst_exit_pulse", restart, 1);
    cyc(1);
    chk("rst_pulse_end", restart, 0);
    chk("rst_pulse_cnt", restart_seen, 1);
    chk("win_after_restart", win_count, 1);

    // Goal boundaries.
    set_icon(600, 439); frames(4);
    chk("edge_x600", gameover, 0);
    set_icon(559, 420); frames(4);
    chk("edge_x559", gameover, 0);
    set_icon(599, 439); frames(3);
    chk("edge_599_439", gameover, 1);
    chk("win_count2", win_count, 2);

    // Reset while in OVER.
    reset = 1'b1; cyc(1);
    chk("midrst_go", gameover, 0);
    chk("midrst_restart", restart, 0);
    chk("midrst_win", win_count, 0);
    reset = 1'b0;
    frames(2);
    chk("midrst_play", gameover, 0);
    chk("midrst_no_pulse", restart_seen, 1);

    // Saturation on the fast instance.
    reset = 1'b1; cyc(1); reset = 1'b0;
    set_icon(570, 410);
    for (int i = 0; i < 256; i++) begin
      frame();
      if (i == 0) begin
        chk("sat_first_go", gameover2, 1);
        chk("sat_first_win", win_count2, 1);
      end
      if (i == 254) chk("sat_255", win_count2, 255);
      btn_restart = 1'b1; cyc(1);
      btn_restart = 1'b0; cyc(1);
      frame();
    end
    chk("sat_hold", win_count2, 255);
    chk("sat_go_play", gameover2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
